// File: rtl/snf_rxreq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snf_rxreq_pkg
//  Brief    : CHI REQ flit layout shared by the SN REQ-link receiver and its users.
//  Revision : 1.0  initial release
// ============================================================================
package snf_rxreq_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OPC_REQLCRDRETURN = 7'h00;
    localparam logic [OPCODE_W-1:0] OPC_READNOSNP     = 7'h04;

    typedef struct packed {
        logic [3:0]          QoS;
        logic [10:0]         TgtID;
        logic [10:0]         SrcID;
        logic [11:0]         TxnID;
        logic [OPCODE_W-1:0] Opcode;
        logic [2:0]          Size;
        logic [51:0]         Addr;
    } reqflit_t;

endpackage
`default_nettype wire

// File: rtl/snf_rxreq.sv
`default_nettype none
// ============================================================================
//  Module   : snf_rxreq
//  Brief    : CHI REQ link receiver: L-credit grant, DEPTH-entry flit FIFO,
//             ReqLCrdReturn absorption and credit drain on link_en=0.
//  Revision : 1.0  initial release
// ============================================================================
module snf_rxreq
    import snf_rxreq_pkg::*;
#(
    parameter int unsigned          DEPTH           = 4,
    parameter logic [OPCODE_W-1:0]  LCRD_RETURN_OPC = 7'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  reqflit_t    RXREQFLIT,
    input  logic        RXREQFLITV,
    input  logic        RXREQFLITPEND,
    output logic        RXREQLCRDV,
    input  logic        link_en,
    output reqflit_t    req_out,
    output logic        req_out_valid,
    input  logic        req_out_ready,
    output logic [3:0]  crd_outstanding,
    output logic [3:0]  occupancy,
    output logic        protocol_err
);

    localparam int unsigned         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0]  c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [4:0]          c_DEPTH = 5'(DEPTH);

    reqflit_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [3:0]         r_crd;
    logic [3:0]         r_occ;
    logic               r_lcrdv;
    logic               r_err;

    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic [3:0]         w_crd_n;
    logic [3:0]         w_occ_n;
    logic [4:0]         w_sum_n;
    logic               w_unused_pend;

    // The early-flit hint carries no information this receiver needs.
    assign w_unused_pend = RXREQFLITPEND;

    assign w_acc   = RXREQFLITV & (r_crd != 4'd0);
    assign w_push  = w_acc & (RXREQFLIT.Opcode != LCRD_RETURN_OPC);
    assign w_pop   = (r_occ != 4'd0) & req_out_ready;
    assign w_crd_n = r_crd + {3'b000, r_lcrdv} - {3'b000, w_acc};
    assign w_occ_n = r_occ + {3'b000, w_push} - {3'b000, w_pop};
    assign w_sum_n = {1'b0, w_crd_n} + {1'b0, w_occ_n};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_crd   <= 4'd0;
            r_occ   <= 4'd0;
            r_lcrdv <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_crd   <= w_crd_n;
            r_occ   <= w_occ_n;
            // Grant only while the next-cycle buffer+credit total leaves room.
            r_lcrdv <= link_en & (w_sum_n < c_DEPTH);
            if (RXREQFLITV && (r_crd == 4'd0)) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= RXREQFLIT;
        end
    end

    assign RXREQLCRDV      = r_lcrdv;
    assign req_out         = r_mem[r_rptr];
    assign req_out_valid   = (r_occ != 4'd0);
    assign crd_outstanding = r_crd;
    assign occupancy       = r_occ;
    assign protocol_err    = r_err;

endmodule
`default_nettype wire
